// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, registered carry.
// Latency: WIDTH+1 edges from the accepting edge to the done pulse.
// Backpressure: start is ignored while busy; a start seen in DONE begins the next add at once.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter reaches WIDTH on the final edge, so it needs room for that value.
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // Full-adder bit slice built from the half-adder sum/carry equations.
    always_comb begin
        w_s      = r_a[0] ^ r_b[0] ^ r_carry;
        w_c_nxt  = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
        w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_last   = (r_state == S_RUN) && (r_cnt == LAST_BIT);
    end

    // Result register shifts right with the new sum bit entering at the MSB;
    // written this way so it also holds for WIDTH == 1.
    always_comb begin
        w_res_nxt             = r_res >> 1;
        w_res_nxt[WIDTH-1]    = w_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial datapath, and result hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_nxt;
            r_carry <= w_c_nxt;
            r_cnt   <= r_cnt + CW'(1);
            // Outputs only move when the last bit is done, never mid-run.
            if (w_last) begin
                sum  <= w_res_nxt;
                cout <= w_c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected {cout,sum} pushed when a start is driven, popped on each done.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       s8_start;
    logic [7:0] s8_a, s8_b, s8_sum;
    logic       s8_busy, s8_done, s8_cout;

    logic       s1_start;
    logic [0:0] s1_a, s1_b, s1_sum;
    logic       s1_busy, s1_done, s1_cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] sb8[$];
    logic [1:0] sb1[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .a_in(s8_a), .b_in(s8_b),
        .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a_in(s1_a), .b_in(s1_b),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
    );

    // Drive one start pulse on the 8-bit DUT; returns after the accepting edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit push);
        s8_a     = a;
        s8_b     = b;
        s8_start = 1'b1;
        if (push) sb8.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s8_start = 1'b0; s8_a = '0; s8_b = '0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({s8_busy, s8_done, s8_cout, s8_sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: busy/done/cout/sum=%b required all 0", {s8_busy, s8_done, s8_cout, s8_sum});
        end
        n_checks++;
        if ({s1_busy, s1_done, s1_cout, s1_sum} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: busy/done/cout/sum=%b required all 0", {s1_busy, s1_done, s1_cout, s1_sum});
        end
        rst = 1'b0;
    endtask

    task automatic test_half_adder();
        for (int i = 0; i < 4; i++) begin
            int  edges;
            bit  seen;
            logic [1:0] exp;
            s1_a     = 1'(i >> 1);
            s1_b     = 1'(i);
            s1_start = 1'b1;
            sb1.push_back({1'b0, s1_a} + {1'b0, s1_b});
            edges = 0;
            seen  = 1'b0;
            while (!seen && edges < 20) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                s1_start = 1'b0;
                if (s1_done) seen = 1'b1;
            end
            n_checks++;
            if (!seen || edges != 2) begin
                n_fail++;
                $display("FAIL ha_latency[%0d]: done after %0d edges (seen=%0d) required 2", i, edges, seen);
            end
            if (seen) begin
                n_checks++;
                if (sb1.size() == 0) begin
                    n_fail++;
                    $display("FAIL ha_scoreboard[%0d]: done with empty queue", i);
                end else begin
                    exp = sb1.pop_front();
                    if ({s1_cout, s1_sum} !== exp) begin
                        n_fail++;
                        $display("FAIL ha_result[%0d]: {cout,sum}=%b required %b", i, {s1_cout, s1_sum}, exp);
                    end
                end
            end
            @(negedge clk);
            n_checks++;
            if (s1_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ha_done_width[%0d]: done=%b one cycle later, required 0", i, s1_done);
            end
        end
    endtask

    // One addition on the 8-bit DUT with latency, hold and handshake checks.
    task automatic test_add8(input logic [7:0] a, input logic [7:0] b, input string name);
        logic [7:0] hold_sum;
        logic [8:0] exp;
        int  edges;
        bit  seen;
        bit  bad_hold;
        bit  bad_overlap;
        hold_sum    = s8_sum;
        bad_hold    = 1'b0;
        bad_overlap = 1'b0;
        seen        = 1'b0;
        go8(a, b, 1'b1);
        edges = 1;
        if (s8_done) seen = 1'b1;
        while (!seen && edges < 40) begin
            if (s8_busy && s8_done) bad_overlap = 1'b1;
            if (s8_sum !== hold_sum) bad_hold = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (s8_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen || edges != 9) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d edges (seen=%0d) required 9", name, edges, seen);
        end
        n_checks++;
        if (bad_hold || bad_overlap || (s8_busy && s8_done)) begin
            n_fail++;
            $display("FAIL %s_during_run: sum_changed=%0d busy_done_overlap=%0d required 0 and 0", name, bad_hold, bad_overlap);
        end
        if (seen) begin
            n_checks++;
            if (sb8.size() == 0) begin
                n_fail++;
                $display("FAIL %s_scoreboard: done with empty queue", name);
            end else begin
                exp = sb8.pop_front();
                if ({s8_cout, s8_sum} !== exp) begin
                    n_fail++;
                    $display("FAIL %s_result: {cout,sum}=0x%03h required 0x%03h", name, {s8_cout, s8_sum}, exp);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (s8_done !== 1'b0 || {s8_cout, s8_sum} !== ({1'b0, a} + {1'b0, b})) begin
            n_fail++;
            $display("FAIL %s_after_done: done=%b {cout,sum}=0x%03h required done=0 and held result", name, s8_done, {s8_cout, s8_sum});
        end
    endtask

    task automatic test_start_while_busy();
        int  edges;
        int  n_done;
        int  done_edge;
        logic [8:0] exp;
        go8(8'h11, 8'h22, 1'b1);
        edges     = 1;
        n_done    = 0;
        done_edge = -1;
        while (edges < 22) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 4) begin
                s8_a = 8'hEE; s8_b = 8'hEE; s8_start = 1'b1;
            end else begin
                s8_start = 1'b0;
            end
            if (s8_done) begin
                n_done++;
                done_edge = edges;
                n_checks++;
                if (sb8.size() == 0) begin
                    n_fail++;
                    $display("FAIL busy_ignore_scoreboard: done with empty queue at edge %0d", edges);
                end else begin
                    exp = sb8.pop_front();
                    if ({s8_cout, s8_sum} !== exp) begin
                        n_fail++;
                        $display("FAIL busy_ignore_result: {cout,sum}=0x%03h required 0x%03h", {s8_cout, s8_sum}, exp);
                    end
                end
            end
        end
        n_checks++;
        if (n_done != 1 || done_edge != 9) begin
            n_fail++;
            $display("FAIL busy_ignore_pulses: %0d done pulses, last at edge %0d, required 1 at edge 9", n_done, done_edge);
        end
    endtask

    task automatic test_reset_midrun();
        int  n_bad;
        go8(8'hAB, 8'hCD, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({s8_busy, s8_done, s8_cout, s8_sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: busy/done/cout/sum=%b required all 0", {s8_busy, s8_done, s8_cout, s8_sum});
        end
        @(negedge clk);
        rst   = 1'b0;
        n_bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (s8_done || s8_busy || s8_sum !== 8'h00 || s8_cout !== 1'b0) n_bad++;
        end
        n_checks++;
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: %0d cycles with activity or nonzero result after reset, required 0", n_bad);
        end
        test_add8(8'h10, 8'h20, "after_reset");
    endtask

    task automatic test_back_to_back();
        int  edges;
        int  n_done;
        int  bad_period;
        int  bad_busy;
        logic [8:0] exp;
        s8_a     = 8'h80;
        s8_b     = 8'h80;
        s8_start = 1'b1;
        repeat (3) sb8.push_back(9'h080 + 9'h080);
        edges      = 0;
        n_done     = 0;
        bad_period = 0;
        bad_busy   = 0;
        while (edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges >= 27) s8_start = 1'b0;
            if (s8_busy === s8_done) bad_busy++;
            if (s8_done) begin
                n_done++;
                if (edges % 9 != 0) bad_period++;
                n_checks++;
                if (sb8.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_scoreboard: done with empty queue at edge %0d", edges);
                end else begin
                    exp = sb8.pop_front();
                    if ({s8_cout, s8_sum} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result: {cout,sum}=0x%03h required 0x%03h at edge %0d", {s8_cout, s8_sum}, exp, edges);
                    end
                end
            end
            if (edges == 27) break;
        end
        n_checks++;
        if (n_done != 3 || bad_period != 0 || bad_busy != 0) begin
            n_fail++;
            $display("FAIL b2b_cadence: %0d dones, %0d off-period, %0d busy/done conflicts, required 3,0,0", n_done, bad_period, bad_busy);
        end
        n_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (s8_done || s8_busy) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL b2b_release: %0d active cycles after start released, required 0", n_done);
        end
    endtask

    initial begin
        test_reset();
        test_half_adder();
        test_add8(8'h5A, 8'h33, "basic");
        test_add8(8'hFF, 8'h01, "ovf_ff01");
        test_add8(8'hFF, 8'hFF, "ovf_ffff");
        test_start_while_busy();
        test_reset_midrun();
        test_back_to_back();
        n_checks++;
        if (sb8.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", sb8.size(), sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
